// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_pkg
// Brief    : shared cache-hierarchy constants and arbiter state encoding
// Revision : 1.0
// ============================================================================
package l2_port_arbiter_pkg;

    localparam int unsigned C_ADDR_W  = 24;
    localparam int unsigned C_DATA_W  = 8;
    localparam int unsigned C_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Returns the requester index to grant; rr breaks a tie between both.
    function automatic logic pick_grant(input logic pend0, input logic pend1, input logic rr);
        return (pend0 && pend1) ? rr : !pend0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arb_watchdog
// Brief    : BUSY-cycle counter flagging the last permitted wait cycle
// Revision : 1.0
// ============================================================================
module arb_watchdog
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = C_TIMEOUT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal_count
);

    localparam int unsigned     CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Fires during the TIMEOUT-th BUSY cycle so the abort lands exactly then.
    assign terminal_count = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Brief    : two-requester round-robin arbiter onto a shared L2 port
// Revision : 1.0
// ============================================================================
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = C_ADDR_W,
    parameter int unsigned DATA_W  = C_DATA_W,
    parameter int unsigned TIMEOUT = C_TIMEOUT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data_out,
    input  logic              req0_read,
    input  logic              req0_write,
    output logic [DATA_W-1:0] req0_data_in,
    output logic              req0_RDY,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data_out,
    input  logic              req1_read,
    input  logic              req1_write,
    output logic [DATA_W-1:0] req1_data_in,
    output logic              req1_RDY,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_RDY,
    output logic              timeout_err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_grant;
    logic              r_rr;
    logic              r_op_read;
    logic              w_pend0;
    logic              w_pend1;
    logic              w_sel;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic              w_tc;
    logic              w_busy;
    logic [DATA_W-1:0] w_rdata;

    assign w_pend0 = req0_read | req0_write;
    assign w_pend1 = req1_read | req1_write;
    assign w_sel   = pick_grant(w_pend0, w_pend1, r_rr);
    assign w_busy  = (r_state == ST_BUSY);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // mem_RDY takes precedence over a coincident terminal count.
                if (mem_RDY) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_tc) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_rr         <= 1'b0;
            r_op_read    <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            timeout_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_grant      <= w_sel;
                r_op_read    <= w_sel ? req1_read     : req0_read;
                mem_addr     <= w_sel ? req1_addr     : req0_addr;
                mem_data_out <= w_sel ? req1_data_out : req0_data_out;
            end
            if (r_state == ST_RESP) begin
                r_rr <= ~r_grant;
            end
            if (w_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign w_rdata = w_done ? mem_data_in : {DATA_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_data_in <= '0;
            req1_data_in <= '0;
        end else if (r_op_read && (w_done || w_abort)) begin
            if (r_grant) begin
                req1_data_in <= w_rdata;
            end else begin
                req0_data_in <= w_rdata;
            end
        end
    end

    assign mem_read  = w_busy &&  r_op_read;
    assign mem_write = w_busy && !r_op_read;
    assign req0_RDY  = (r_state == ST_RESP) && !r_grant;
    assign req1_RDY  = (r_state == ST_RESP) &&  r_grant;

    arb_watchdog #(
        .TIMEOUT        (TIMEOUT)
    ) u_watchdog (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (w_start),
        .enable         (w_busy),
        .terminal_count (w_tc)
    );

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Brief    : scoreboard bench with an L2 responder model and random requesters
// Revision : 1.0
// ============================================================================
module tb_l2_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data_out, req1_data_out;
    logic          req0_read, req0_write, req1_read, req1_write;
    logic [DW-1:0] req0_data_in, req1_data_in;
    logic          req0_RDY, req1_RDY;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_out, mem_data_in;
    logic          mem_read, mem_write, mem_RDY;
    logic          timeout_err;

    l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_addr(req0_addr), .req0_data_out(req0_data_out), .req0_read(req0_read),
        .req0_write(req0_write), .req0_data_in(req0_data_in), .req0_RDY(req0_RDY),
        .req1_addr(req1_addr), .req1_data_out(req1_data_out), .req1_read(req1_read),
        .req1_write(req1_write), .req1_data_in(req1_data_in), .req1_RDY(req1_RDY),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_read(mem_read),
        .mem_write(mem_write), .mem_data_in(mem_data_in), .mem_RDY(mem_RDY),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit            is_read;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            tout;
    } exp_t;

    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    int            wait_q0[$];
    int            wait_q1[$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] l2_mem    [logic [AW-1:0]];
    logic [DW-1:0] last_rd   [2];
    int            grant_log[$];
    int            checks   = 0;
    int            failures = 0;
    bit            sticky   = 0;
    bit            rr_exp   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop(input int n);
        if (n == 0) begin req0_read = 1'b0; req0_write = 1'b0; end
        else        begin req1_read = 1'b0; req1_write = 1'b0; end
    endtask

    // Issue a request and record what the arbiter must eventually return for it.
    task automatic start_req(input int n, input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int w);
        exp_t e;
        e.is_read = rd;
        e.addr    = a;
        e.wdata   = d;
        e.tout    = (w >= TO);
        if (rd) begin
            e.rdata    = e.tout ? 8'hFF : (model_mem.exists(a) ? model_mem[a] : dflt(a));
            last_rd[n] = e.rdata;
        end else begin
            e.rdata = last_rd[n];
            if (!e.tout) model_mem[a] = d;
        end
        if (n == 0) begin
            exp_q0.push_back(e); wait_q0.push_back(w);
            req0_addr = a; req0_data_out = d; req0_read = rd; req0_write = wr;
        end else begin
            exp_q1.push_back(e); wait_q1.push_back(w);
            req1_addr = a; req1_data_out = d; req1_read = rd; req1_write = wr;
        end
    endtask

    task automatic wait_rdy(input int n, output int lat);
        bit seen = 0;
        lat = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = (n == 0) ? req0_RDY : req1_RDY;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_rdy%0d: got no RDY expected RDY within 40 cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_any(output int n);
        int  cnt  = 0;
        bit  seen = 0;
        n = 0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            seen = req0_RDY | req1_RDY;
            n    = req1_RDY ? 1 : 0;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_any: got no RDY expected RDY within 40 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic flush_model();
        exp_q0.delete(); exp_q1.delete(); wait_q0.delete(); wait_q1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        sticky = 0; rr_exp = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; drop(0); drop(1);
        flush_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // L2 responder: honours the wait chosen by the requester, junk strobes when idle.
    bit            l2_in_txn = 0;
    int            l2_bcnt   = 0;
    int            l2_wait   = 0;
    initial begin
        mem_RDY     = 1'b0;
        mem_data_in = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (mem_read || mem_write)) begin
                if (!l2_in_txn) begin
                    l2_in_txn = 1; l2_bcnt = 0; l2_wait = 0;
                    if (!mem_addr[AW-1] && wait_q0.size() > 0) l2_wait = wait_q0.pop_front();
                    if ( mem_addr[AW-1] && wait_q1.size() > 0) l2_wait = wait_q1.pop_front();
                end else begin
                    l2_bcnt++;
                end
                mem_RDY = (l2_bcnt == l2_wait);
                if (mem_read) mem_data_in = l2_mem.exists(mem_addr) ? l2_mem[mem_addr] : dflt(mem_addr);
                else          mem_data_in = DW'($urandom);
                if (mem_RDY && mem_write) l2_mem[mem_addr] = mem_data_out;
            end else begin
                l2_in_txn   = 0;
                mem_RDY     = ($urandom_range(0, 3) == 0);
                mem_data_in = DW'($urandom);
            end
        end
    end

    // Monitor: grant order, L2 port contents and completions against the model.
    bit            m_prev_act = 0;
    bit            m_pend0 = 0, m_pend1 = 0;
    bit            m_cur_g = 0;
    logic [AW-1:0] m_a_hold;
    logic [DW-1:0] m_d_hold;
    initial begin
        bit   act, n, exp_g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_prev_act = 0; m_pend0 = 0; m_pend1 = 0;
                continue;
            end
            act = mem_read | mem_write;
            if (act) check("strobe_onehot", {31'd0, mem_read & mem_write}, 32'd0);
            if (act && !m_prev_act) begin
                n     = mem_addr[AW-1];
                exp_g = (m_pend0 && m_pend1) ? rr_exp : !m_pend0;
                check("grant", {31'd0, n}, {31'd0, exp_g});
                grant_log.push_back(int'(n));
                m_cur_g  = n;
                m_a_hold = mem_addr;
                m_d_hold = mem_data_out;
                if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected: got transaction for req%0d expected none", n);
                end else begin
                    e = (n == 0) ? exp_q0[0] : exp_q1[0];
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_op_read", {31'd0, mem_read}, {31'd0, e.is_read});
                    if (!e.is_read) check("mem_wdata", mem_data_out, e.wdata);
                end
            end else if (act) begin
                check("mem_stable", {mem_addr, mem_data_out}, {m_a_hold, m_d_hold});
            end
            if (req0_RDY || req1_RDY) begin
                n = req1_RDY;
                check("rdy_onehot", {31'd0, req0_RDY & req1_RDY}, 32'd0);
                check("rdy_grant", {31'd0, n}, {31'd0, m_cur_g});
                if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                    checks++; failures++;
                    $display("FAIL rdy_unexpected: got RDY on req%0d expected none", n);
                end else begin
                    e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("data_in", (n == 0) ? req0_data_in : req1_data_in, e.rdata);
                    if (e.tout) sticky = 1;
                    check("timeout_err", {31'd0, timeout_err}, {31'd0, sticky});
                end
                rr_exp = !n;
            end
            m_prev_act = act;
            m_pend0    = req0_read | req0_write;
            m_pend1    = req1_read | req1_write;
        end
    end

    task automatic rand_req(input int n);
        int            lat;
        bit            rd, wr;
        logic [AW-1:0] a;
        logic [3:0]    lo;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) begin
                drop(n);
                @(posedge clk); #1;
            end
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            lo = 4'($urandom_range(0, 15));
            a  = {(n == 1), 19'd0, lo};
            start_req(n, rd, wr, a, DW'($urandom), $urandom_range(0, 5));
            wait_rdy(n, lat);
        end
        drop(n);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400000");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat, n, cnt;
        rst_n = 1'b0;
        req0_addr = '0; req0_data_out = '0; req0_read = 1'b0; req0_write = 1'b0;
        req1_addr = '0; req1_data_out = '0; req1_read = 1'b0; req1_write = 1'b0;
        flush_model();
        l2_mem[24'h000010]    = 8'hA5;
        model_mem[24'h000010] = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_read",  {31'd0, mem_read},    32'd0);
        check("rst_mem_write", {31'd0, mem_write},   32'd0);
        check("rst_rdy0",      {31'd0, req0_RDY},    32'd0);
        check("rst_rdy1",      {31'd0, req1_RDY},    32'd0);
        check("rst_err",       {31'd0, timeout_err}, 32'd0);
        check("rst_mem_addr",  mem_addr,     32'd0);
        check("rst_mem_wdata", mem_data_out, 32'd0);
        check("rst_data_in0",  req0_data_in, 32'd0);
        check("rst_data_in1",  req1_data_in, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait single read
        start_req(0, 1, 0, 24'h000010, 8'h00, 0);
        wait_rdy(0, lat); drop(0);
        check("single_read_latency", lat, 3);
        check("single_read_data", req0_data_in, 8'hA5);

        // mem_RDY coincident with terminal count
        start_req(0, 1, 1, 24'h000020, 8'h00, TO - 1);
        wait_rdy(0, lat); drop(0);
        check("race_latency", lat, 6);
        check("race_data", req0_data_in, 8'h7A);
        check("race_err", {31'd0, timeout_err}, 32'd0);

        // Simultaneous writes straight after reset
        do_reset();
        grant_log.delete();
        start_req(0, 0, 1, 24'h000030, 8'h11, 0);
        start_req(1, 0, 1, 24'h800030, 8'h22, 0);
        wait_rdy(0, lat); drop(0);
        wait_rdy(1, lat); drop(1);
        check("sim_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("sim_first", grant_log[0], 0);
            check("sim_second", grant_log[1], 1);
        end

        // Both continuously requesting
        grant_log.delete();
        start_req(0, 1, 0, 24'h000031, 8'h00, 1);
        start_req(1, 1, 0, 24'h800031, 8'h00, 1);
        for (int k = 0; k < 4; k++) begin
            wait_any(n);
            if (k < 2) start_req(n, 1, 0, {(n == 1), 19'd0, 4'(k + 2)}, 8'h00, 0);
            else       drop(n);
        end
        check("fair_count", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++) check("fair_order", grant_log[k], k % 2);

        // Watchdog abort on req1
        start_req(1, 1, 0, 24'h800040, 8'h00, 99);
        wait_rdy(1, lat); drop(1);
        check("tout_latency", lat, 6);
        check("tout_data", req1_data_in, 8'hFF);
        check("tout_err", {31'd0, timeout_err}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("tout_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of BUSY
        start_req(0, 1, 0, 24'h000050, 8'h00, 99);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0; drop(0);
        #1;
        check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        check("midrst_rdy0", {31'd0, req0_RDY}, 32'd0);
        flush_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (req0_RDY || req1_RDY) cnt++;
        end
        check("midrst_no_rdy", cnt, 0);
        check("midrst_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clk); #1;
        start_req(0, 1, 0, 24'h000060, 8'h00, 0);
        wait_rdy(0, lat); drop(0);
        check("midrst_next_latency", lat, 3);

        // Random contention
        fork
            rand_req(0);
            rand_req(1);
        join
        repeat (6) @(posedge clk);
        #1;
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
